spinner_array: RTL and testbench

//  Multi-channel rotary-control generator for arcade cores that need a dial angle.
//  It converts digital left/right buttons and MiSTer spinner deltas into a W-bit angle per channel.
//  It generalises the single-channel spinner: NCH independent channels, fractional analog scaling,

---
 rtl/spinner_array.sv | 104 ++++++++++
 tb/tb_spinner_array.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spinner_array.sv
// Multi-channel dial-angle generator: strobe-stepped buttons plus MiSTer spinner deltas,
// accumulated with FRAC fractional bits per channel, in wrap or clamp mode.
module spinner_array #(
  parameter int NCH        = 2,
  parameter int W          = 4,
  parameter int STEP       = 1,
  parameter int FAST_SHIFT = 1,
  parameter int FRAC       = 2,
  parameter int WRAP       = 1,
  parameter int INIT       = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NCH-1:0]     clear,
  input  logic               strobe,
  input  logic [NCH-1:0]     minus,
  input  logic [NCH-1:0]     plus,
  input  logic [NCH-1:0]     fast,
  input  logic [9*NCH-1:0]   spin_in,
  output logic [W*NCH-1:0]   angle,
  output logic [NCH-1:0]     changed
);

  localparam int AW = W + FRAC;
  // Sum width leaves room for a full 8-bit delta and the largest button step on top of acc.
  localparam int NW = AW + FAST_SHIFT + $clog2(STEP + 1) + 10;

  localparam logic signed [NW-1:0] STEP_SLOW = NW'(STEP << FRAC);
  localparam logic signed [NW-1:0] STEP_FAST = NW'(STEP << (FAST_SHIFT + FRAC));
  localparam logic signed [NW-1:0] ACC_MAX   = NW'((1 << AW) - 1);
  localparam logic [AW-1:0]        ACC_INIT  = AW'(INIT << FRAC);

  logic                      strobe_q, strobe_d;
  logic                      primed_q, primed_d;
  logic [NCH-1:0]            shadow_q, shadow_d;
  logic [NCH-1:0][AW-1:0]    acc_q, acc_d;
  logic [NCH-1:0][W-1:0]     angle_q, angle_d;
  logic [NCH-1:0]            changed_q, changed_d;

  logic                      se;
  logic signed [NW-1:0]      bd  [NCH];
  logic signed [NW-1:0]      sd  [NCH];
  logic signed [NW-1:0]      nxt [NCH];

  always_comb begin
    se        = strobe & ~strobe_q;
    strobe_d  = strobe;
    primed_d  = 1'b1;
    shadow_d  = '0;
    acc_d     = acc_q;
    angle_d   = angle_q;
    changed_d = '0;
    for (int i = 0; i < NCH; i++) begin
      bd[i] = '0;
      sd[i] = '0;
      if (se && plus[i] && !minus[i]) begin
        bd[i] = fast[i] ? STEP_FAST : STEP_SLOW;
      end else if (se && minus[i] && !plus[i]) begin
        bd[i] = fast[i] ? -STEP_FAST : -STEP_SLOW;
      end
      // Shadow tracks the toggle even when cleared, so a pending sample is dropped.
      shadow_d[i] = spin_in[9*i+8];
      if (primed_q && (spin_in[9*i+8] != shadow_q[i])) begin
        sd[i] = NW'($signed(spin_in[9*i +: 8]));
      end
      nxt[i] = $signed({{(NW-AW){1'b0}}, acc_q[i]}) + bd[i] + sd[i];
      if (clear[i]) begin
        acc_d[i] = ACC_INIT;
      end else if (WRAP != 0) begin
        acc_d[i] = nxt[i][AW-1:0];
      end else if (nxt[i] < 0) begin
        acc_d[i] = '0;
      end else if (nxt[i] > ACC_MAX) begin
        acc_d[i] = '1;
      end else begin
        acc_d[i] = nxt[i][AW-1:0];
      end
      angle_d[i]   = acc_q[i][AW-1:FRAC];
      changed_d[i] = (angle_d[i] != angle_q[i]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q  <= 1'b0;
      primed_q  <= 1'b0;
      shadow_q  <= '0;
      acc_q     <= {NCH{ACC_INIT}};
      angle_q   <= {NCH{W'(INIT)}};
      changed_q <= '0;
    end else begin
      strobe_q  <= strobe_d;
      primed_q  <= primed_d;
      shadow_q  <= shadow_d;
      acc_q     <= acc_d;
      angle_q   <= angle_d;
      changed_q <= changed_d;
    end
  end

  assign angle   = angle_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_spinner_array.sv
// Bench for spinner_array: a wrap and a clamp instance share stimulus and are checked
// every cycle against an integer reference model of the dial accumulators.
module tb_spinner_array;

  localparam int NCH        = 2;
  localparam int W          = 4;
  localparam int STEP       = 1;
  localparam int FAST_SHIFT = 1;
  localparam int FRAC       = 2;
  localparam int INIT       = 0;
  localparam int MODW       = 1 << (W + FRAC);

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [NCH-1:0]     clear;
  logic               strobe;
  logic [NCH-1:0]     minus;
  logic [NCH-1:0]     plus;
  logic [NCH-1:0]     fast;
  logic [9*NCH-1:0]   spin_in;
  logic [W*NCH-1:0]   angle_w, angle_c;
  logic [NCH-1:0]     changed_w, changed_c;

  always #5 clk_sys = ~clk_sys;

  spinner_array #(.NCH(NCH), .W(W), .STEP(STEP), .FAST_SHIFT(FAST_SHIFT), .FRAC(FRAC),
                  .WRAP(1), .INIT(INIT)) u_wrap (
    .clk_sys(clk_sys), .reset_n(reset_n), .clear(clear), .strobe(strobe),
    .minus(minus), .plus(plus), .fast(fast), .spin_in(spin_in),
    .angle(angle_w), .changed(changed_w));

  spinner_array #(.NCH(NCH), .W(W), .STEP(STEP), .FAST_SHIFT(FAST_SHIFT), .FRAC(FRAC),
                  .WRAP(0), .INIT(INIT)) u_clamp (
    .clk_sys(clk_sys), .reset_n(reset_n), .clear(clear), .strobe(strobe),
    .minus(minus), .plus(plus), .fast(fast), .spin_in(spin_in),
    .angle(angle_c), .changed(changed_c));

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = wrap instance, 1 = clamp instance.
  int m_acc [2][NCH];
  int m_ang [2][NCH];
  bit m_chg [2][NCH];
  bit m_shadow [NCH];
  bit m_strobe;
  bit m_primed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_acc[d][ch] = INIT * (2 ** FRAC);
        m_ang[d][ch] = INIT;
        m_chg[d][ch] = 1'b0;
      end
    end
    for (int ch = 0; ch < NCH; ch++) m_shadow[ch] = 1'b0;
    m_strobe = 1'b0;
    m_primed = 1'b0;
  endtask

  task automatic model_edge();
    int  sdel [NCH];
    bit  se;
    int  s;
    int  nxt;
    logic [8:0] smp;
    byte dl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    se = strobe && !m_strobe;
    for (int ch = 0; ch < NCH; ch++) begin
      smp = spin_in[9*ch +: 9];
      dl  = smp[7:0];
      sdel[ch] = (m_primed && (smp[8] != m_shadow[ch])) ? int'(dl) : 0;
      m_shadow[ch] = smp[8];
    end
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        s = (fast[ch] ? STEP * (2 ** FAST_SHIFT) : STEP) * (2 ** FRAC);
        nxt = m_acc[d][ch] + sdel[ch];
        if (se && plus[ch] && !minus[ch]) nxt = nxt + s;
        else if (se && minus[ch] && !plus[ch]) nxt = nxt - s;
        m_chg[d][ch] = (m_acc[d][ch] / (2 ** FRAC)) != m_ang[d][ch];
        m_ang[d][ch] = m_acc[d][ch] / (2 ** FRAC);
        if (clear[ch]) m_acc[d][ch] = INIT * (2 ** FRAC);
        else if (d == 0) m_acc[d][ch] = ((nxt % MODW) + MODW) % MODW;
        else m_acc[d][ch] = (nxt < 0) ? 0 : (nxt > MODW - 1) ? MODW - 1 : nxt;
      end
    end
    m_primed = 1'b1;
    m_strobe = strobe;
  endtask

  task automatic check_all();
    logic [W*NCH-1:0] ea [2];
    logic [NCH-1:0]   ec [2];
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        ea[d][W*ch +: W] = W'(m_ang[d][ch]);
        ec[d][ch]        = m_chg[d][ch];
      end
    end
    chk("angle_wrap",    angle_w,   ea[0]);
    chk("angle_clamp",   angle_c,   ea[1]);
    chk("changed_wrap",  changed_w, ec[0]);
    chk("changed_clamp", changed_c, ec[1]);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      model_edge();
      @(negedge clk_sys);
      check_all();
    end
  endtask

  task automatic set_spin(input int ch, input logic t, input logic [7:0] d);
    spin_in[9*ch +: 9] = {t, d};
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = '0;
    strobe  = 1'b0;
    minus   = '0;
    plus    = '0;
    fast    = '0;
    spin_in = '0;
    set_spin(0, 1'b1, 8'h05);
    model_reset();
    @(negedge clk_sys);
    check_all();
    cyc(2);

    // Release with ch0 toggle already high: priming must swallow it.
    reset_n = 1'b1;
    cyc(10);
    chk("prime_angle0", angle_w[W-1:0], 0);
    chk("prime_changed", changed_w, 0);

    // Three button steps on ch0, then strobe held high.
    plus[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      strobe = 1'b0;
      cyc(1);
      strobe = 1'b1;
      cyc(2);
      chk("btn_angle", angle_w[W-1:0], k);
      chk("btn_pulse", changed_w[0], 1);
      cyc(1);
      chk("btn_pulse_end", changed_w[0], 0);
    end
    cyc(100);
    chk("strobe_held", angle_w[W-1:0], 3);
    strobe = 1'b0;
    cyc(1);

    // Spinner deltas on ch1.
    set_spin(1, 1'b1, 8'd6);
    cyc(2);
    chk("spin_pos_angle", angle_w[2*W-1:W], 1);
    chk("spin_pos_pulse", changed_w[1], 1);
    set_spin(1, 1'b0, 8'hFD);
    cyc(2);
    chk("spin_neg_angle", angle_c[2*W-1:W], 0);
    chk("spin_neg_pulse", changed_c[1], 1);

    // Drive ch0 to 15 then one more step: wrap vs clamp.
    for (int k = 0; k < 12; k++) begin
      strobe = 1'b1;
      cyc(1);
      strobe = 1'b0;
      cyc(1);
    end
    chk("top_wrap", angle_w[W-1:0], 15);
    chk("top_clamp", angle_c[W-1:0], 15);
    strobe = 1'b1;
    cyc(2);
    chk("over_wrap", angle_w[W-1:0], 0);
    chk("over_clamp", angle_c[W-1:0], 15);
    strobe = 1'b0;
    plus   = '0;
    cyc(1);

    // Fast minus cancelled by spinner +8 in the same cycle.
    minus[0] = 1'b1;
    fast[0]  = 1'b1;
    strobe   = 1'b1;
    set_spin(0, 1'b0, 8'd8);
    cyc(3);
    chk("net0_wrap", angle_w[W-1:0], 0);
    chk("net0_clamp", angle_c[W-1:0], 15);
    chk("net0_pulse", changed_c[0], 0);
    minus  = '0;
    fast   = '0;
    strobe = 1'b0;
    cyc(1);

    // Clear wins over a coincident strobe edge, plus and toggle.
    clear[0] = 1'b1;
    strobe   = 1'b1;
    plus[0]  = 1'b1;
    set_spin(0, 1'b1, 8'd5);
    cyc(1);
    clear  = '0;
    strobe = 1'b0;
    plus   = '0;
    cyc(3);
    chk("clear_wrap", angle_w[W-1:0], 0);
    chk("clear_clamp", angle_c[W-1:0], 0);

    // Randomized traffic including rare clears and mid-run resets.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cyc(1);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) strobe = ~strobe;
      plus  = NCH'($urandom);
      minus = NCH'($urandom);
      fast  = NCH'($urandom);
      clear = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 2) == 0) set_spin(ch, ~spin_in[9*ch+8], 8'($urandom));
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
